// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial line in plus decoded character outputs of the
// frame receiver. The receiver uses the slave modport; whoever drives the
// line and consumes characters uses master.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 7
);
  logic                 s_in;
  logic                 received;
  logic [DATA_BITS-1:0] received_data;
  logic                 check;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output s_in,
    input  received, received_data, check, frame_err, busy
  );

  modport slave (
    input  s_in,
    output received, received_data, check, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: receiver for start + DATA_BITS (LSB first) + even parity +
// stop frames. Each bit is sampled at its middle, timed from the edge that
// first sees the start level.
// Optional macro UART_RX_SYNC_EN inserts a 2-flop input synchronizer, which
// delays every sample point by 2 cycles without changing decoded values.
//
// state     | meaning
// ST_IDLE   | line idle, waiting for the start level
// ST_START  | waiting for mid start bit to confirm it (else glitch)
// ST_DATA   | sampling data bits at their middle, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling stop bit, publishing the character
module uart_rx_frame #(
  parameter logic START_SIG  = 1'b1,
  parameter int   BIT_CYCLES = 4,
  parameter int   DATA_BITS  = 7
) (
  input logic             clk,
  input logic             rst,
  uart_rx_frame_if.slave  bus
);

  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Down-counter reloads: reaching zero marks the sample edge.
  localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
  localparam logic          IDLE_LVL  = ~START_SIG;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_check;
  logic                 rx_ferr;
  logic                 rx_pulse;
  logic                 s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer, parked at the idle level so reset never looks like a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {2{IDLE_LVL}};
    else     sync_q <= {sync_q[0], bus.s_in};
  end

  assign s = sync_q[1];
`else
  assign s = bus.s_in;
`endif

  // Frame decoder: start detection, mid-bit sampling and character publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      rx_data  <= '0;
      rx_check <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_pulse <= 1'b0;
    end else begin
      rx_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s == START_SIG) begin
            state <= ST_START;
            cnt   <= HALF_LOAD;
          end
        end
        ST_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (s == START_SIG) begin
            state <= ST_DATA;
            idx   <= '0;
            cnt   <= BIT_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {s, shreg[DATA_BITS-1:1]};
            cnt   <= BIT_LOAD;
            if (idx == LAST_IDX) state <= ST_PARITY;
            else                 idx   <= idx + 1'b1;
          end
        end
        ST_PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            par_bit <= s;
            cnt     <= BIT_LOAD;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // A bad stop bit still publishes the character, only flagged.
            rx_data  <= shreg;
            rx_check <= (par_bit == ^shreg);
            rx_ferr  <= (s != IDLE_LVL);
            rx_pulse <= 1'b1;
            cnt      <= '0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.received      = rx_pulse;
  assign bus.received_data = rx_data;
  assign bus.check         = rx_check;
  assign bus.frame_err     = rx_ferr;
  assign bus.busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: drives whole frames onto s_in and compares every received
// pulse (time, character, parity flag, framing flag) against what a
// frame-level model expects from the bits that were sent.
module tb_uart_rx_frame;

  localparam logic START_SIG  = 1'b1;
  localparam int   BIT_CYCLES = 4;
  localparam int   DATA_BITS  = 7;
  localparam logic IDLE_LVL   = ~START_SIG;
`ifdef UART_RX_SYNC_EN
  localparam int   SYNC_LAT   = 2;
`else
  localparam int   SYNC_LAT   = 0;
`endif
  // Edges from start detection to the received pulse (mid stop bit).
  localparam int   PULSE_LAT  = BIT_CYCLES / 2 + (DATA_BITS + 2) * BIT_CYCLES;

  typedef struct {
    int                   cyc;
    logic [DATA_BITS-1:0] d;
    logic                 chk;
    logic                 fe;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  rec_t obs_q[$];
  rec_t exp_q[$];

  uart_rx_frame_if #(.DATA_BITS(DATA_BITS)) bus ();

  uart_rx_frame #(
    .START_SIG (START_SIG),
    .BIT_CYCLES(BIT_CYCLES),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.received === 1'b1)
      obs_q.push_back('{cyc, bus.received_data, bus.check, bus.frame_err});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached, required finish before it");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the first nbits of a frame; a complete frame also records the
  // character the receiver should report and the cycle it should report it.
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit par_flip,
                            input bit stop_bad, input int nbits);
    logic [DATA_BITS+2:0] bits;
    int start_cyc;
    bits[0] = START_SIG;
    for (int i = 0; i < DATA_BITS; i++) bits[i+1] = d[i];
    bits[DATA_BITS+1] = (^d) ^ par_flip;
    bits[DATA_BITS+2] = stop_bad ? START_SIG : IDLE_LVL;
    start_cyc = cyc;
    for (int j = 0; j < nbits; j++) begin
      bus.s_in = bits[j];
      tick(BIT_CYCLES);
    end
    bus.s_in = IDLE_LVL;
    if (nbits == DATA_BITS + 3)
      exp_q.push_back('{start_cyc + 1 + PULSE_LAT + SYNC_LAT, d, !par_flip, stop_bad});
  endtask

  task automatic flush(input string tag);
    int n;
    tick(2 * BIT_CYCLES + 4);
    chk({tag, ".pulses"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, ".cycle"}, obs_q[i].cyc, exp_q[i].cyc);
      chk({tag, ".data"},  32'(obs_q[i].d), 32'(exp_q[i].d));
      chk({tag, ".check"}, 32'(obs_q[i].chk), 32'(exp_q[i].chk));
      chk({tag, ".ferr"},  32'(obs_q[i].fe), 32'(exp_q[i].fe));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [DATA_BITS-1:0] snap_d;
    logic snap_c, snap_f;
    int busy_cnt;

    bus.s_in = IDLE_LVL;
    tick(3);
    chk("rst.received",  32'(bus.received), 0);
    chk("rst.data",      32'(bus.received_data), 0);
    chk("rst.check",     32'(bus.check), 0);
    chk("rst.frame_err", 32'(bus.frame_err), 0);
    chk("rst.busy",      32'(bus.busy), 0);
    rst = 1'b0;
    tick(4);

    send_frame(7'h48, 1'b0, 1'b0, DATA_BITS + 3);
    flush("nominal_H");

    send_frame(7'h79, 1'b1, 1'b0, DATA_BITS + 3);
    flush("parity_err");

    send_frame(7'h65, 1'b0, 1'b1, DATA_BITS + 3);
    flush("frame_err");

    snap_d = bus.received_data;
    snap_c = bus.check;
    snap_f = bus.frame_err;
    busy_cnt = 0;
    bus.s_in = START_SIG;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (i == 0) bus.s_in = IDLE_LVL;
      if (bus.busy === 1'b1) busy_cnt++;
    end
    chk("glitch.busy_cycles", busy_cnt, 2);
    chk("glitch.data",  32'(bus.received_data), 32'(snap_d));
    chk("glitch.check", 32'(bus.check), 32'(snap_c));
    chk("glitch.ferr",  32'(bus.frame_err), 32'(snap_f));
    flush("glitch");

    send_frame(7'h42, 1'b0, 1'b0, DATA_BITS + 3);
    send_frame(7'h79, 1'b0, 1'b0, DATA_BITS + 3);
    send_frame(7'h65, 1'b0, 1'b0, DATA_BITS + 3);
    flush("b2b");

    // Abort "l" during data bit 3, then a clean "o" must be the only character.
    send_frame(7'h6C, 1'b0, 1'b0, 4);
    bus.s_in = 1'b1;
    tick(2);
    rst = 1'b1;
    #1;
    chk("midrst.received",  32'(bus.received), 0);
    chk("midrst.data",      32'(bus.received_data), 0);
    chk("midrst.check",     32'(bus.check), 0);
    chk("midrst.frame_err", 32'(bus.frame_err), 0);
    chk("midrst.busy",      32'(bus.busy), 0);
    tick(2);
    bus.s_in = IDLE_LVL;
    rst = 1'b0;
    tick(3 * BIT_CYCLES);
    send_frame(7'h6F, 1'b0, 1'b0, DATA_BITS + 3);
    flush("midrst");

    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 4; k++) begin
        logic [DATA_BITS-1:0] d;
        bit pf, sb;
        int gap;
        d   = DATA_BITS'($urandom);
        pf  = ($urandom_range(3) == 0);
        sb  = ($urandom_range(4) == 0);
        gap = $urandom_range(3);
        send_frame(d, pf, sb, DATA_BITS + 3);
        tick(sb ? BIT_CYCLES + gap : gap);
      end
      flush("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
